fetch_stage: RTL and testbench

Instruction fetch stage of the CpuPkg in-order pipeline and transmitting end of the `inst_packet_if` channel that feeds the decode stage. It owns the program counter, issues word-aligned requests to instruction memory, and buffers in-order responses in a small instruction queue. It presents `{pc, inst}` packets to decode with valid/ready handshaking, and discards stale in-flight fetches on a redirect from execute.

---
 rtl/fetch_stage_pkg.sv | 36 +++
 rtl/inst_packet_if.sv | 12 +
 rtl/fetch_stage_inst_queue.sv | 62 ++++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its decode channel.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned INST_BYTES = 4;

  typedef logic [7:0] uop_t;

  typedef struct packed {
    word_t rs1Data;
    word_t rs2Data;
  } regfile_r_resp_st;

  typedef struct packed {
    word_t            pc;
    word_t            inst;
    uop_t             uop;
    word_t            imm;
    regfile_r_resp_st regfile_r_resp;
  } inst_packet_st;

  typedef struct packed {
    word_t addr;
  } imem_req_st;

  typedef struct packed {
    word_t data;
  } imem_resp_st;

  // Instruction addresses are always word aligned; the low two bits are simply dropped.
  function automatic word_t alignWord(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_packet_if.sv
// Valid/ready channel carrying fetched instruction packets from fetch to decode.
interface inst_packet_if;
  import fetch_stage_pkg::*;

  logic          valid;
  logic          ready;
  inst_packet_st inst_packet;

  modport out (output valid, output inst_packet, input ready);
  modport in  (input valid, input inst_packet, output ready);

endinterface

// File: rtl/fetch_stage_inst_queue.sv
// Small synchronous FIFO holding fetched instruction words until decode takes them.
module InstQueue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q;
  logic [PW-1:0]    wrPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush;
  logic             doPop;

  // Pointers wrap at DEPTH so non-power-of-two depths work too.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Ignore pushes into a full queue and pops from an empty one rather than corrupting state.
  always_comb begin
    doPush = push_i && !full_o;
    doPop  = pop_i && !empty_o;
  end

  // Pointer and occupancy bookkeeping; clear and reset both empty the queue.
  always_ff @(posedge i_clk) begin
    if (i_rst || clear_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
      if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge i_clk) begin
    if (doPush && !clear_i && !i_rst) mem_q[wrPtr_q] <= pushData_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited memory reads and hands packets to decode.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter word_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_redirect_valid,
  input  word_t         i_redirect_pc,
  output logic          o_imem_req_valid,
  output word_t         o_imem_req_addr,
  input  logic          i_imem_req_ready,
  input  logic          i_imem_resp_valid,
  input  word_t         i_imem_resp_data,
  inst_packet_if.out    if_decode_out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  word_t         pc_q;
  word_t         pc_d;
  word_t         deliverPc_q;
  word_t         deliverPc_d;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_d;

  logic [CW-1:0] queueCount;
  word_t         queueHead;
  logic          queueFull;
  logic          queueEmpty;
  logic          queuePush;
  logic          queuePop;

  logic          decValid;
  logic          decFire;
  logic          reqValid;
  logic          reqFire;
  logic          respDrop;
  logic [SW-1:0] creditUsed;
  word_t         redirectTarget;
  imem_req_st    imemReq;
  imem_resp_st   imemResp;

  // Handshake and credit decisions. The entry leaving the queue this cycle frees its credit
  // immediately, which is what lets a one-cycle memory sustain one instruction per cycle.
  always_comb begin
    redirectTarget = alignWord(i_redirect_pc);
    imemResp.data  = i_imem_resp_data;
    decValid       = !i_rst && !queueEmpty;
    decFire        = decValid && if_decode_out.ready && !i_redirect_valid;
    creditUsed     = SW'(outstanding_q) + SW'(queueCount) - SW'(decFire);
    reqValid       = !i_rst && !i_redirect_valid && (creditUsed < SW'(DEPTH));
    reqFire        = reqValid && i_imem_req_ready;
    respDrop       = i_imem_resp_valid && (drop_q != '0);
    queuePush      = i_imem_resp_valid && (drop_q == '0) && !i_redirect_valid && !i_rst;
    queuePop       = decFire;
  end

  // Next-state for the PC pair and the in-flight/stale counters; a redirect overrides normal flow
  // and turns every fetch still in memory into one that must be thrown away.
  always_comb begin
    pc_d          = pc_q;
    deliverPc_d   = deliverPc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (i_redirect_valid) begin
      pc_d          = redirectTarget;
      deliverPc_d   = redirectTarget;
      outstanding_d = outstanding_q - CW'(i_imem_resp_valid);
      drop_d        = outstanding_q - CW'(i_imem_resp_valid);
    end else begin
      if (reqFire)  pc_d = pc_q + word_t'(INST_BYTES);
      if (decFire)  deliverPc_d = deliverPc_q + word_t'(INST_BYTES);
      if (respDrop) drop_d = drop_q - CW'(1);
      outstanding_d = outstanding_q + CW'(reqFire) - CW'(i_imem_resp_valid);
    end
  end

  // State registers with synchronous reset back to the boot PC and an idle pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      deliverPc_q   <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      deliverPc_q   <= deliverPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // The credit scheme should make a push into a full queue impossible; flag it if it ever happens.
  always_ff @(posedge i_clk) begin
    if (!i_rst && queuePush) assert (!queueFull);
  end

  InstQueue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(word_t))
  ) instQueue (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .clear_i    (i_redirect_valid),
    .push_i     (queuePush),
    .pushData_i (imemResp.data),
    .pop_i      (queuePop),
    .count_o    (queueCount),
    .head_o     (queueHead),
    .full_o     (queueFull),
    .empty_o    (queueEmpty)
  );

  // Drive the memory request and the decode packet; decode-side fields fetch does not own stay unknown.
  always_comb begin
    imemReq.addr                          = pc_q;
    o_imem_req_valid                      = reqValid;
    o_imem_req_addr                       = imemReq.addr;
    if_decode_out.valid                   = decValid;
    if_decode_out.inst_packet.pc          = deliverPc_q;
    if_decode_out.inst_packet.inst        = queueHead;
    if_decode_out.inst_packet.uop         = 'x;
    if_decode_out.inst_packet.imm         = 'x;
    if_decode_out.inst_packet.regfile_r_resp = 'x;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences and random traffic
// against a queue-based reference model and a latency-programmable memory.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t RESET_PC = 32'h0000_0100;
  localparam int    DEPTH    = 2;

  logic  clk = 1'b0;
  logic  rst;
  logic  redirectValid;
  word_t redirectPc;
  logic  imemReqValid;
  word_t imemReqAddr;
  logic  imemReqReady;
  logic  imemRespValid;
  word_t imemRespData;

  inst_packet_if decodeIf ();

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_redirect_valid  (redirectValid),
    .i_redirect_pc     (redirectPc),
    .o_imem_req_valid  (imemReqValid),
    .o_imem_req_addr   (imemReqAddr),
    .i_imem_req_ready  (imemReqReady),
    .i_imem_resp_valid (imemRespValid),
    .i_imem_resp_data  (imemRespData),
    .if_decode_out     (decodeIf)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int memLatency = 1;

  typedef struct { int due; word_t addr; } memReq_t;
  typedef struct { word_t addr; bit stale; } flight_t;
  typedef struct { word_t pc; word_t inst; } pkt_t;

  memReq_t memPend[$];
  flight_t refFlight[$];
  pkt_t    refQueue[$];
  word_t   refPc = RESET_PC;

  word_t delivered[$];
  word_t reqAddrs[$];
  int    reqFireCount = 0;

  logic  sampReqValid;
  word_t sampReqAddr;
  logic  sampDecValid;
  word_t sampDecPc;

  typedef struct {
    bit    rst;
    bit    decReady;
    bit    redir;
    word_t redirPc;
    bit    expReqValid;
    word_t expReqAddr;
    bit    expDecValid;
    word_t expPc;
  } vec_t;

  vec_t vecs[12];

  function automatic word_t memData(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic word_t qAt(input word_t q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock cycle: drive inputs, let the memory answer, check against the model, then advance.
  task automatic applyStimulus(input bit r, input bit decReady, input bit reqReady,
                               input bit redir, input word_t redirPc);
    bit      expDecValid;
    bit      popping;
    bit      expReqValid;
    int      used;
    bit      respNow;
    flight_t f;
    @(negedge clk);
    rst            = r;
    decodeIf.ready = decReady;
    imemReqReady   = reqReady;
    redirectValid  = redir;
    redirectPc     = redirPc;
    respNow        = !r && memPend.size() > 0 && memPend[0].due == cyc;
    imemRespValid  = respNow;
    imemRespData   = respNow ? memData(memPend[0].addr) : 32'h0;
    #1;
    sampReqValid = imemReqValid;
    sampReqAddr  = imemReqAddr;
    sampDecValid = decodeIf.valid;
    sampDecPc    = decodeIf.inst_packet.pc;

    expDecValid = refQueue.size() != 0;
    popping     = expDecValid && decReady && !redir;
    used        = refFlight.size() + refQueue.size() - (popping ? 1 : 0);
    expReqValid = !r && !redir && (used < DEPTH);

    checkOutput("model.reqValid", word_t'(imemReqValid), word_t'(expReqValid));
    if (expReqValid) checkOutput("model.reqAddr", imemReqAddr, refPc);
    if (!r) begin
      checkOutput("model.decValid", word_t'(decodeIf.valid), word_t'(expDecValid));
      if (expDecValid) begin
        checkOutput("model.decPc", decodeIf.inst_packet.pc, refQueue[0].pc);
        checkOutput("model.decInst", decodeIf.inst_packet.inst, refQueue[0].inst);
      end
    end

    if (decodeIf.valid === 1'b1 && decReady && !redir && !r) delivered.push_back(decodeIf.inst_packet.pc);
    if (imemReqValid === 1'b1 && reqReady) begin
      reqAddrs.push_back(imemReqAddr);
      reqFireCount++;
    end

    if (r) begin
      refFlight.delete();
      refQueue.delete();
      refPc = RESET_PC;
    end else begin
      if (respNow && refFlight.size() > 0) begin
        f = refFlight.pop_front();
        if (!f.stale && !redir) refQueue.push_back('{pc: f.addr, inst: memData(f.addr)});
      end
      if (redir) begin
        foreach (refFlight[i]) refFlight[i].stale = 1'b1;
        refQueue.delete();
        refPc = {redirPc[31:2], 2'b00};
      end else begin
        if (popping) void'(refQueue.pop_front());
        if (expReqValid && reqReady) begin
          refFlight.push_back('{addr: refPc, stale: 1'b0});
          refPc = refPc + 32'd4;
        end
      end
    end

    if (r) memPend.delete();
    else begin
      if (respNow) void'(memPend.pop_front());
      if (imemReqValid === 1'b1 && reqReady) memPend.push_back('{due: cyc + memLatency, addr: imemReqAddr});
    end

    @(posedge clk);
    cyc++;
  endtask

  task automatic runCycles(input int n, input bit decReady, input bit reqReady);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, decReady, reqReady, 1'b0, 32'h0);
  endtask

  // Stop issuing long enough for everything in memory to return and decode to empty the queue.
  task automatic drain();
    runCycles(8, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    redirectValid  = 1'b0;
    redirectPc     = 32'h0;
    imemReqReady   = 1'b1;
    imemRespValid  = 1'b0;
    imemRespData   = 32'h0;
    decodeIf.ready = 1'b1;

    // Reset, back-to-back delivery from 0x100 with a one-cycle memory, then a redirect to 0x2003.
    vecs[0]  = '{1, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0};
    vecs[1]  = '{1, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0};
    vecs[2]  = '{0, 1, 0, 32'h0,    1, 32'h100,  0, 32'h0};
    vecs[3]  = '{0, 1, 0, 32'h0,    1, 32'h104,  0, 32'h0};
    vecs[4]  = '{0, 1, 0, 32'h0,    1, 32'h108,  1, 32'h100};
    vecs[5]  = '{0, 1, 0, 32'h0,    1, 32'h10C,  1, 32'h104};
    vecs[6]  = '{0, 1, 0, 32'h0,    1, 32'h110,  1, 32'h108};
    vecs[7]  = '{0, 1, 1, 32'h2003, 0, 32'h0,    1, 32'h10C};
    vecs[8]  = '{0, 1, 0, 32'h0,    1, 32'h2000, 0, 32'h0};
    vecs[9]  = '{0, 1, 0, 32'h0,    1, 32'h2004, 0, 32'h0};
    vecs[10] = '{0, 1, 0, 32'h0,    1, 32'h2008, 1, 32'h2000};
    vecs[11] = '{0, 1, 0, 32'h0,    1, 32'h200C, 1, 32'h2004};

    memLatency = 1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].decReady, 1'b1, vecs[i].redir, vecs[i].redirPc);
      checkOutput($sformatf("vec%0d.reqValid", i), word_t'(sampReqValid), word_t'(vecs[i].expReqValid));
      if (vecs[i].expReqValid) checkOutput($sformatf("vec%0d.reqAddr", i), sampReqAddr, vecs[i].expReqAddr);
      if (!vecs[i].rst) begin
        checkOutput($sformatf("vec%0d.decValid", i), word_t'(sampDecValid), word_t'(vecs[i].expDecValid));
        if (vecs[i].expDecValid) checkOutput($sformatf("vec%0d.decPc", i), sampDecPc, vecs[i].expPc);
      end
    end

    // Decode stalled for 10 cycles: only two fetches may go out and the head packet must hold.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    reqFireCount = 0;
    runCycles(10, 1'b0, 1'b1);
    checkOutput("stall.reqCount", word_t'(reqFireCount), 32'd2);
    checkOutput("stall.decValid", word_t'(sampDecValid), 32'd1);
    checkOutput("stall.decPc", sampDecPc, 32'h0);
    delivered.delete();
    runCycles(6, 1'b1, 1'b1);
    checkOutput("stall.deliverCount", word_t'(delivered.size()), 32'd6);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("stall.deliver%0d", i), qAt(delivered, i), word_t'(4 * i));

    // Two fetches in flight with a three-cycle memory, then redirect: both stale words vanish.
    drain();
    memLatency = 3;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h3000);
    runCycles(2, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h2003);
    delivered.delete();
    reqAddrs.delete();
    runCycles(10, 1'b1, 1'b1);
    checkOutput("redirL3.firstReq", qAt(reqAddrs, 0), 32'h2000);
    checkOutput("redirL3.firstPc", qAt(delivered, 0), 32'h2000);

    // Redirect in the very cycle a response lands, with one more still in memory.
    drain();
    memLatency = 2;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000);
    runCycles(2, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h5000);
    delivered.delete();
    reqAddrs.delete();
    runCycles(8, 1'b1, 1'b1);
    checkOutput("redirResp.firstReq", qAt(reqAddrs, 0), 32'h5000);
    checkOutput("redirResp.firstPc", qAt(delivered, 0), 32'h5000);
    checkOutput("redirResp.secondPc", qAt(delivered, 1), 32'h5004);

    // Memory refuses requests for 5 cycles: request holds steady and nothing reaches decode.
    drain();
    begin
      word_t heldPc;
      heldPc = refPc;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput($sformatf("reqHold%0d.valid", i), word_t'(sampReqValid), 32'd1);
        checkOutput($sformatf("reqHold%0d.addr", i), sampReqAddr, heldPc);
        checkOutput($sformatf("reqHold%0d.decValid", i), word_t'(sampDecValid), 32'd0);
      end
    end

    // PC wraps past the top of the address space.
    drain();
    memLatency = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA);
    reqAddrs.delete();
    runCycles(4, 1'b1, 1'b1);
    checkOutput("wrap.req0", qAt(reqAddrs, 0), 32'hFFFF_FFF8);
    checkOutput("wrap.req1", qAt(reqAddrs, 1), 32'hFFFF_FFFC);
    checkOutput("wrap.req2", qAt(reqAddrs, 2), 32'h0000_0000);

    // Reset with a queued packet and a fetch still in memory.
    drain();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h6000);
    runCycles(2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    delivered.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("postReset.decValid", word_t'(sampDecValid), 32'd0);
    checkOutput("postReset.reqValid", word_t'(sampReqValid), 32'd1);
    checkOutput("postReset.reqAddr", sampReqAddr, RESET_PC);
    runCycles(3, 1'b1, 1'b1);
    checkOutput("postReset.firstPc", qAt(delivered, 0), RESET_PC);

    // Random traffic in segments of fixed memory latency.
    for (int seg = 0; seg < 4; seg++) begin
      drain();
      memLatency = $urandom_range(1, 3);
      for (int i = 0; i < 150; i++) begin
        bit    r;
        bit    rd;
        bit    rq;
        bit    rdir;
        word_t tgt;
        r    = ($urandom_range(0, 149) == 0);
        rd   = ($urandom_range(0, 3) != 0);
        rq   = ($urandom_range(0, 3) != 0);
        rdir = ($urandom_range(0, 19) == 0);
        tgt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : word_t'($urandom);
        applyStimulus(r, rd, rq, rdir, tgt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
